// File: rtl/reg_file_mp.sv
// Multi-port register file (NUM_RD async reads, 2 sync writes) with busy scoreboard and sequenced clear; optional RF_PARITY_EN.
// Reads and busy are combinational; writes and allocs take effect at the edge; o_ready gates all traffic, no backpressure.
module reg_file_mp #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 32,
  parameter int NUM_RD    = 2,
  parameter int BYPASS_EN = 1,
  parameter int ZERO_REG  = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  output logic                   o_ready,
  input  logic [NUM_RD*AW-1:0]   i_raddr,
  output logic [NUM_RD*XLEN-1:0] o_rdata,
  output logic [NUM_RD-1:0]      o_rbusy,
  input  logic                   i_w0_en,
  input  logic [AW-1:0]          i_w0_addr,
  input  logic [XLEN-1:0]        i_w0_data,
  input  logic                   i_w1_en,
  input  logic [AW-1:0]          i_w1_addr,
  input  logic [XLEN-1:0]        i_w1_data,
  input  logic                   i_alloc_en,
  input  logic [AW-1:0]          i_alloc_addr
`ifdef RF_PARITY_EN
  ,
  output logic [NUM_RD-1:0]      o_perr
`endif
);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t           r_state, w_state_nxt;
  logic [AW-1:0]    r_cnt;
  logic [XLEN-1:0]  r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy, w_busy_nxt;
  logic             w_ready, w_w0_ok, w_w1_ok, w_alloc_ok;
`ifdef RF_PARITY_EN
  logic             r_par [DEPTH];
`endif

  // Address 0 is dead when hardwired to zero: no writes, no allocs, reads 0.
  function automatic logic f_live(input logic [AW-1:0] a);
    return !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign w_ready    = (r_state == S_READY);
  assign o_ready    = w_ready;
  assign w_w0_ok    = w_ready && i_rst_n && i_w0_en    && f_live(i_w0_addr);
  assign w_w1_ok    = w_ready && i_rst_n && i_w1_en    && f_live(i_w1_addr);
  assign w_alloc_ok = w_ready && i_rst_n && i_alloc_en && f_live(i_alloc_addr);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (r_cnt == AW'(DEPTH-1)) w_state_nxt = S_READY;
      S_READY: w_state_nxt = S_READY;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // Alloc is applied last so a same-cycle producer keeps the register busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_w0_ok)    w_busy_nxt[i_w0_addr]    = 1'b0;
    if (w_w1_ok)    w_busy_nxt[i_w1_addr]    = 1'b0;
    if (w_alloc_ok) w_busy_nxt[i_alloc_addr] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
      r_busy  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CLEAR) r_cnt <= r_cnt + 1'b1;
      r_busy  <= w_busy_nxt;
    end
  end

  // Port 1 is written last so it wins on an address collision.
  always_ff @(posedge i_clk) begin
    if (r_state == S_CLEAR) begin
      if (i_rst_n) begin
        r_mem[r_cnt] <= '0;
`ifdef RF_PARITY_EN
        r_par[r_cnt] <= 1'b0;
`endif
      end
    end else begin
      if (w_w0_ok) begin
        r_mem[i_w0_addr] <= i_w0_data;
`ifdef RF_PARITY_EN
        r_par[i_w0_addr] <= ^i_w0_data;
`endif
      end
      if (w_w1_ok) begin
        r_mem[i_w1_addr] <= i_w1_data;
`ifdef RF_PARITY_EN
        r_par[i_w1_addr] <= ^i_w1_data;
`endif
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_zero, w_hit0, w_hit1, w_alloc_hit;

    assign w_ra        = i_raddr[k*AW +: AW];
    assign w_zero      = !f_live(w_ra);
    assign w_hit0      = (BYPASS_EN != 0) && w_w0_ok && (i_w0_addr == w_ra);
    assign w_hit1      = (BYPASS_EN != 0) && w_w1_ok && (i_w1_addr == w_ra);
    assign w_alloc_hit = w_alloc_ok && (i_alloc_addr == w_ra);

    assign o_rdata[k*XLEN +: XLEN] = (!w_ready || w_zero) ? '0 :
                                     w_hit1 ? i_w1_data :
                                     w_hit0 ? i_w0_data : r_mem[w_ra];

    assign o_rbusy[k] = (!w_ready || w_zero) ? 1'b0 :
                        ((w_hit0 || w_hit1) && !w_alloc_hit) ? 1'b0 : r_busy[w_ra];
`ifdef RF_PARITY_EN
    assign o_perr[k] = (!w_ready || w_zero || w_hit0 || w_hit1) ? 1'b0 :
                       (r_par[w_ra] != ^r_mem[w_ra]);
`endif
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench: dut_a uses defaults (bypass, zero reg); dut_b has BYPASS_EN=0, ZERO_REG=0 on the same stimulus.
module tb_reg_file_mp;
  logic        clk;
  logic        rst_n;
  logic [9:0]  raddr;
  logic        w0_en, w1_en, alloc_en;
  logic [4:0]  w0_addr, w1_addr, alloc_addr;
  logic [31:0] w0_data, w1_data;
  logic        ready_a, ready_b;
  logic [63:0] rdata_a, rdata_b;
  logic [1:0]  rbusy_a, rbusy_b;
`ifdef RF_PARITY_EN
  logic [1:0]  perr_a, perr_b;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  reg_file_mp dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .o_ready(ready_a), .i_raddr(raddr),
    .o_rdata(rdata_a), .o_rbusy(rbusy_a),
    .i_w0_en(w0_en), .i_w0_addr(w0_addr), .i_w0_data(w0_data),
    .i_w1_en(w1_en), .i_w1_addr(w1_addr), .i_w1_data(w1_data),
    .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr)
`ifdef RF_PARITY_EN
    , .o_perr(perr_a)
`endif
  );

  reg_file_mp #(.BYPASS_EN(0), .ZERO_REG(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .o_ready(ready_b), .i_raddr(raddr),
    .o_rdata(rdata_b), .o_rbusy(rbusy_b),
    .i_w0_en(w0_en), .i_w0_addr(w0_addr), .i_w0_data(w0_data),
    .i_w1_en(w1_en), .i_w1_addr(w1_addr), .i_w1_data(w1_data),
    .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr)
`ifdef RF_PARITY_EN
    , .o_perr(perr_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    w0_en = 1'b0; w1_en = 1'b0; alloc_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; raddr = '0; idle();
    w0_addr = '0; w1_addr = '0; alloc_addr = '0; w0_data = '0; w1_data = '0;
    tick(); tick();
    chk("rst_ready_a", ready_a, 0);
    chk("rst_ready_b", ready_b, 0);
    chk("rst_rdata_b", rdata_b[31:0], 0);
    chk("rst_rbusy_a", rbusy_a, 0);

    // First clear run, traffic at clear cycle 2, then reset again at cycle 10.
    rst_n = 1'b1;
    tick(); tick();
    w0_en = 1'b1; w0_addr = 5'd4; w0_data = 32'hAA; alloc_en = 1'b1; alloc_addr = 5'd4;
    raddr = {5'd4, 5'd4};
    #1;
    chk("clr_rdata_a", rdata_a[31:0], 0);
    chk("clr_rdata_b", rdata_b[63:32], 0);
    chk("clr_rbusy_a", rbusy_a, 0);
    tick(); idle();
    repeat (7) tick();
    chk("clr10_ready_a", ready_a, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Second run: late write/alloc to x4 after its entry has been cleared.
    repeat (10) tick();
    w0_en = 1'b1; w0_addr = 5'd4; w0_data = 32'hAA; alloc_en = 1'b1; alloc_addr = 5'd4;
    tick(); idle();
    repeat (20) tick();
    chk("clr31_ready_a", ready_a, 0);
    chk("clr31_ready_b", ready_b, 0);
    tick();
    chk("clr32_ready_a", ready_a, 1);
    chk("clr32_ready_b", ready_b, 1);

    for (int a = 0; a < 32; a++) begin
      raddr = {a[4:0], a[4:0]};
      #1;
      chk("sweep_a", rdata_a[31:0], 0);
      chk("sweep_b", rdata_b[63:32], 0);
      tick();
    end
    raddr = {5'd4, 5'd4};
    #1;
    chk("x4_busy_a", rbusy_a, 0);
    chk("x4_busy_b", rbusy_b, 0);

    // Dual write to distinct addresses.
    w0_en = 1'b1; w0_addr = 5'd5; w0_data = 32'hDEAD_BEEF;
    w1_en = 1'b1; w1_addr = 5'd6; w1_data = 32'h1234_5678;
    raddr = {5'd6, 5'd5};
    tick(); idle();
    #1;
    chk("dw_a_p0", rdata_a[31:0], 32'hDEAD_BEEF);
    chk("dw_a_p1", rdata_a[63:32], 32'h1234_5678);
    chk("dw_b_p0", rdata_b[31:0], 32'hDEAD_BEEF);
    chk("dw_b_p1", rdata_b[63:32], 32'h1234_5678);

    // Same-address collision: port 1 wins.
    w0_en = 1'b1; w0_addr = 5'd7; w0_data = 32'h1;
    w1_en = 1'b1; w1_addr = 5'd7; w1_data = 32'h2;
    raddr = {5'd6, 5'd7};
    #1;
    chk("col_byp_a", rdata_a[31:0], 32'h2);
    chk("col_old_b", rdata_b[31:0], 32'h0);
    tick(); idle();
    #1;
    chk("col_a", rdata_a[31:0], 32'h2);
    chk("col_b", rdata_b[31:0], 32'h2);

    // Bypass of data and busy on a pending register.
    alloc_en = 1'b1; alloc_addr = 5'd9; raddr = {5'd6, 5'd9};
    tick(); idle();
    #1;
    chk("alloc9_busy_a", rbusy_a[0], 1);
    chk("alloc9_busy_b", rbusy_b[0], 1);
    w1_en = 1'b1; w1_addr = 5'd9; w1_data = 32'hCAFE_F00D;
    #1;
    chk("byp_data_a", rdata_a[31:0], 32'hCAFE_F00D);
    chk("byp_busy_a", rbusy_a[0], 0);
    chk("nobyp_data_b", rdata_b[31:0], 32'h0);
    chk("nobyp_busy_b", rbusy_b[0], 1);
    tick(); idle();
    #1;
    chk("w9_data_a", rdata_a[31:0], 32'hCAFE_F00D);
    chk("w9_data_b", rdata_b[31:0], 32'hCAFE_F00D);
    chk("w9_busy_b", rbusy_b[0], 0);

    // Zero register.
    w0_en = 1'b1; w0_addr = 5'd0; w0_data = 32'hFFFF_FFFF; alloc_en = 1'b1; alloc_addr = 5'd0;
    raddr = {5'd6, 5'd0};
    tick(); idle();
    #1;
    chk("x0_data_a", rdata_a[31:0], 32'h0);
    chk("x0_busy_a", rbusy_a[0], 0);
    chk("x0_data_b", rdata_b[31:0], 32'hFFFF_FFFF);
    chk("x0_busy_b", rbusy_b[0], 1);

    // Scoreboard on x3 through read port 1.
    raddr = {5'd3, 5'd0};
    alloc_en = 1'b1; alloc_addr = 5'd3;
    #1;
    chk("sb_pre_a", rbusy_a[1], 0);
    tick(); idle();
    #1;
    chk("sb_set_a", rbusy_a[1], 1);
    chk("sb_set_b", rbusy_b[1], 1);
    w0_en = 1'b1; w0_addr = 5'd3; w0_data = 32'h55;
    #1;
    chk("sb_byp_a", rbusy_a[1], 0);
    chk("sb_nobyp_b", rbusy_b[1], 1);
    chk("sb_bypd_a", rdata_a[63:32], 32'h55);
    tick(); idle();
    #1;
    chk("sb_clr_a", rbusy_a[1], 0);
    chk("sb_clr_b", rbusy_b[1], 0);
    chk("sb_data_b", rdata_b[63:32], 32'h55);
    alloc_en = 1'b1; alloc_addr = 5'd3;
    w1_en = 1'b1; w1_addr = 5'd3; w1_data = 32'h55;
    #1;
    chk("sb_aw_comb_a", rbusy_a[1], 0);
    tick(); idle();
    #1;
    chk("sb_aw_a", rbusy_a[1], 1);
    chk("sb_aw_b", rbusy_b[1], 1);
    chk("sb_aw_data_a", rdata_a[63:32], 32'h55);

`ifdef RF_PARITY_EN
    raddr = {5'd4, 5'd5};
    #1;
    chk("par_ok_a", perr_a, 0);
    dut_a.r_mem[4] = 32'h1;
    #1;
    chk("par_err_a", perr_a, 2'b10);
    tick();
`endif

    // Reset from READY drops ready and blanks reads.
    raddr = {5'd3, 5'd5};
    rst_n = 1'b0;
    tick();
    chk("rerst_ready_a", ready_a, 0);
    chk("rerst_rdata_a", rdata_a[31:0], 0);
    chk("rerst_busy_b", rbusy_b, 0);
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
